imm_encoder: RTL and testbench

- Inverse of the pipeline's immediate decode path: packs a 32-bit immediate into the bit fields of an RV32I instruction word for I/S/B/J/U formats.
- Also expands the `li rd, imm32` pseudo-instruction into one or two real instructions (ADDI, or LUI then ADDI).
- Sits between the debug/boot instruction injector and the fetch-side instruction mux.
- Registered output with valid/ready handshakes on both sides.

---
 rtl/imm_encoder.sv | 138 +++++++++++++
 tb/tb_imm_encoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// ============================================================================
// imm_encoder
// Packs a 32-bit immediate into RV32I I/S/B/J/U fields. Also expands the
// li pseudo-instruction into ADDI, or into LUI followed by ADDI.
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_encoder #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_sel,
    input  logic [DW-1:0] in_imm,
    input  logic [DW-1:0] in_base,
    input  logic [4:0]    in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_inst,
    output logic          out_last,
    output logic          out_err
);

    localparam logic [2:0] SEL_I  = 3'b000;
    localparam logic [2:0] SEL_S  = 3'b001;
    localparam logic [2:0] SEL_B  = 3'b010;
    localparam logic [2:0] SEL_J  = 3'b011;
    localparam logic [2:0] SEL_U  = 3'b100;
    localparam logic [2:0] SEL_LI = 3'b101;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] pend_inst;

    logic          accept;
    logic [DW-1:0] enc_inst;
    logic          enc_err;
    logic          enc_last;
    logic          enc_two;
    logic [DW-1:0] enc_addi2;
    logic          fits12;
    logic [11:0]   lo;
    logic [19:0]   hi;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The +0x800 rounding of hi only ever carries in from bit 11.
    assign lo     = in_imm[11:0];
    assign hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    assign fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);

    always_comb begin
        enc_inst  = in_base;
        enc_err   = 1'b0;
        enc_last  = 1'b1;
        enc_two   = 1'b0;
        enc_addi2 = {lo, in_rd, 3'b000, in_rd, OP_IMM};
        case (in_sel)
            SEL_I: begin
                enc_inst = {in_imm[11:0], in_base[19:0]};
                enc_err  = !fits12;
            end
            SEL_S: begin
                enc_inst = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
                enc_err  = !fits12;
            end
            SEL_B: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_base[24:12],
                            in_imm[4:1], in_imm[11], in_base[6:0]};
                enc_err  = !((&in_imm[31:12]) | ~(|in_imm[31:12])) || in_imm[0];
            end
            SEL_J: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11],
                            in_imm[19:12], in_base[11:0]};
                enc_err  = !((&in_imm[31:20]) | ~(|in_imm[31:20])) || in_imm[0];
            end
            SEL_U: begin
                enc_inst = {in_imm[31:12], in_base[11:0]};
                enc_err  = |in_imm[11:0];
            end
            SEL_LI: begin
                if (fits12) begin
                    enc_inst = {lo, 5'd0, 3'b000, in_rd, OP_IMM};
                end else begin
                    enc_inst = {hi, in_rd, OP_LUI};
                    enc_two  = |lo;
                    enc_last = ~(|lo);
                end
            end
            default: begin
                enc_inst = in_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            pend_inst <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_last  <= enc_last;
            out_err   <= enc_err;
            if (enc_two) begin
                state     <= PEND;
                pend_inst <= enc_addi2;
            end
        end else if (state == PEND && out_valid && out_ready) begin
            out_valid <= 1'b1;
            out_inst  <= pend_inst;
            out_last  <= 1'b1;
            out_err   <= 1'b0;
            state     <= IDLE;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// tb_imm_encoder
// Directed-vector bench for imm_encoder with hand-computed expected words.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    imm_encoder #(.DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns #1 after the accepting edge.
    task automatic send(input logic [2:0] sel, input logic [31:0] imm,
                        input logic [31:0] base, input logic [4:0] rd);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_imm   = imm;
        in_base  = base;
        in_rd    = rd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic word(input string tag, input logic [31:0] inst,
                        input logic last, input logic err);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_inst"},  out_inst, inst);
        chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
        chk({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 3'b000;
        in_imm    = 32'd0;
        in_base   = 32'd0;
        in_rd     = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst",  out_inst, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_err",   {31'd0, out_err}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Field encodings
        send(3'b010, 32'hFFFF_FFFC, 32'h0000_0063, 5'd0);
        word("b_neg", 32'hFE00_0EE3, 1'b1, 1'b0);
        step();
        chk("b_drain", {31'd0, out_valid}, 32'd0);

        send(3'b000, 32'h0000_0001, 32'hFFF0_0013, 5'd0);
        word("i_replace", 32'h0010_0013, 1'b1, 1'b0);
        send(3'b000, 32'hFFFF_F800, 32'h0000_0093, 5'd0);
        word("i_min", 32'h8000_0093, 1'b1, 1'b0);
        send(3'b001, 32'h0000_07FF, 32'h0000_2023, 5'd0);
        word("s_max", 32'h7E00_2FA3, 1'b1, 1'b0);
        send(3'b100, 32'hABCD_E000, 32'h0000_0537, 5'd0);
        word("u_ok", 32'hABCD_E537, 1'b1, 1'b0);

        // Range errors and illegal select
        send(3'b000, 32'h0000_0800, 32'h0000_0013, 5'd0);
        word("i_range", 32'h8000_0013, 1'b1, 1'b1);
        send(3'b011, 32'h0000_0003, 32'h0000_006F, 5'd0);
        word("j_odd", 32'h0020_006F, 1'b1, 1'b1);
        send(3'b100, 32'h0000_1001, 32'h0000_0037, 5'd0);
        word("u_low", 32'h0000_1037, 1'b1, 1'b1);
        send(3'b110, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0);
        word("illegal", 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();

        // li expansions
        send(3'b101, 32'h1234_5FFF, 32'hFFFF_FFFF, 5'd5);
        word("li2_lui", 32'h1234_62B7, 1'b0, 1'b0);
        chk("li2_busy", {31'd0, in_ready}, 32'd0);
        step();
        word("li2_addi", 32'hFFF2_8293, 1'b1, 1'b0);
        step();
        chk("li2_done", {31'd0, out_valid}, 32'd0);

        send(3'b101, 32'hFFFF_FFFB, 32'd0, 5'd1);
        word("li_short", 32'hFFB0_0093, 1'b1, 1'b0);
        send(3'b101, 32'h0001_0000, 32'd0, 5'd2);
        word("li_lui", 32'h0001_0137, 1'b1, 1'b0);
        step();
        chk("li_lui_done", {31'd0, out_valid}, 32'd0);

        // Backpressure during a two-word li
        out_ready = 1'b0;
        send(3'b101, 32'h1234_5FFF, 32'd0, 5'd5);
        for (int i = 0; i < 5; i++) begin
            word("bp_hold", 32'h1234_62B7, 1'b0, 1'b0);
            chk("bp_busy", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        word("bp_lui", 32'h1234_62B7, 1'b0, 1'b0);
        step();
        word("bp_addi", 32'hFFF2_8293, 1'b1, 1'b0);
        step();
        chk("bp_done", {31'd0, out_valid}, 32'd0);

        // Reset while the ADDI is pending
        out_ready = 1'b0;
        send(3'b101, 32'h1234_5FFF, 32'd0, 5'd5);
        word("rp_lui", 32'h1234_62B7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rp_async", {31'd0, out_valid}, 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rp_idle_valid", {31'd0, out_valid}, 32'd0);
            chk("rp_idle_ready", {31'd0, in_ready}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
